// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary to packed BCD
// converter, one input bit per clock. Feeds per-digit 7-segment decoders;
// out-of-range inputs render as 4'hF on every digit (shown as a dash).
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  conversion request, sampled on rising edge (ignored while busy)
//   bin    WIDTH-bit unsigned input, captured when start is accepted
//   busy   high during the WIDTH shift cycles
//   done   one-cycle pulse when bcd/ovf update
//   bcd    4*DIGITS packed digits, digit 0 (units) in bits [3:0]
//   ovf    last converted value exceeded 10^DIGITS - 1
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Compare in a width wide enough for both the input and the capacity so a
  // narrow input never truncates the limit; when bin cannot exceed the limit
  // the comparison folds to constant 0.
  localparam int unsigned CAP_BITS = $clog2(pow10(DIGITS));
  localparam int unsigned CMP_W    = (WIDTH > CAP_BITS) ? WIDTH : CAP_BITS;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(pow10(DIGITS) - 64'd1);
  localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
  localparam int unsigned BW       = 4 * DIGITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [BW-1:0]       scratch;
  logic [BW-1:0]       adj;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pending;
  logic [BW+WIDTH-1:0] joined;
  logic [CMP_W-1:0]    bin_ext;
  logic                over;

  // Add-3 correction per digit (no inter-digit carry), then shift the
  // combined {scratch, shreg} left so the shreg MSB enters scratch bit 0.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    joined  = {adj, shreg} << 1;
    bin_ext = CMP_W'(bin);
    over    = bin_ext > LIMIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      ovf         <= 1'b0;
      shreg       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            shreg       <= bin;
            scratch     <= '0;
            cnt         <= CNT_W'(WIDTH);
            ovf_pending <= over;
            busy        <= 1'b1;
            state       <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= joined[BW+WIDTH-1:WIDTH];
          shreg   <= joined[WIDTH-1:0];
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= ovf_pending ? '1 : joined[BW+WIDTH-1:WIDTH];
            ovf   <= ovf_pending;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: two instances (DIGITS=3 and DIGITS=2, WIDTH=8)
// checked every cycle against a decimal-arithmetic reference model, plus
// directed literal checks for latency, back-to-back, busy-ignore, reset abort.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  bin_a = '0, bin_b = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, or all-F when above capacity.
  function automatic logic [11:0] ref_bcd(input int v, input int nd);
    logic [11:0] r;
    int lim, p;
    r = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = (v >= lim) ? 4'hF : 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Model: a conversion accepted at an edge finishes 8 edges later.
  int          m_left[2] = '{0, 0};
  bit          m_done[2] = '{0, 0};
  logic [11:0] m_bcd[2]  = '{12'h0, 12'h0};
  bit          m_ovf[2]  = '{0, 0};
  int          m_bin[2]  = '{0, 0};
  int          m_nd[2]   = '{3, 2};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_left[i] <= 0; m_done[i] <= 0; m_bcd[i] <= '0; m_ovf[i] <= 0;
      end else if (m_left[i] > 0) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) begin
          m_done[i] <= 1;
          m_bcd[i]  <= ref_bcd(m_bin[i], m_nd[i]);
          m_ovf[i]  <= (m_bin[i] > ((m_nd[i] == 3) ? 999 : 99));
        end
      end else begin
        m_done[i] <= 0;
        if ((i == 0) ? start_a : start_b) begin
          m_bin[i]  <= (i == 0) ? int'(bin_a) : int'(bin_b);
          m_left[i] <= 8;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy_a", busy_a, m_left[0] > 0);
    chk("done_a", done_a, m_done[0]);
    chk("bcd_a",  bcd_a,  m_bcd[0]);
    chk("ovf_a",  ovf_a,  m_ovf[0]);
    chk("busy_b", busy_b, m_left[1] > 0);
    chk("done_b", done_b, m_done[1]);
    chk("bcd_b",  bcd_b,  m_bcd[1][7:0]);
    chk("ovf_b",  ovf_b,  m_ovf[1]);
    chk("busy_and_done_a", busy_a & done_a, 1'b0);
  end

  // Called at a falling edge: raise start for exactly one rising edge.
  task automatic start_now(input int idx, input logic [7:0] v);
    #1;
    if (idx == 0) begin start_a = 1'b1; bin_a = v; end
    else          begin start_b = 1'b1; bin_b = v; end
    @(negedge clk);
    #1;
    if (idx == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  task automatic pulse(input int idx, input logic [7:0] v);
    @(negedge clk);
    start_now(idx, v);
  endtask

  // Bounded wait for done; returns falling edges waited, stops at a falling edge.
  task automatic wait_done(input int idx, output int cycles);
    cycles = 0;
    while (((idx == 0) ? done_a : done_b) !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (((idx == 0) ? done_a : done_b) !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_bcd",  bcd_a,  12'h000);
    chk("rst_ovf",  ovf_a,  1'b0);
    #1 rst_n = 1'b1;

    // 255: latency and value
    pulse(0, 8'd255);
    chk("busy_after_start", busy_a, 1'b1);
    wait_done(0, c);
    chk("latency_255", c, 8);
    chk("bcd_255", bcd_a, 12'h255);
    chk("ovf_255", ovf_a, 1'b0);

    // Back-to-back 0, 7, 100 with start during DONE
    pulse(0, 8'd0);
    wait_done(0, c);
    chk("bcd_0", bcd_a, 12'h000);
    start_now(0, 8'd7);
    wait_done(0, c);
    chk("b2b_spacing_7", c + 1, 9);
    chk("bcd_7", bcd_a, 12'h007);
    start_now(0, 8'd100);
    wait_done(0, c);
    chk("b2b_spacing_100", c + 1, 9);
    chk("bcd_100", bcd_a, 12'h100);

    // DIGITS=2 overflow boundary
    pulse(1, 8'd100);
    wait_done(1, c);
    chk("bcd_b_100", bcd_b, 8'hFF);
    chk("ovf_b_100", ovf_b, 1'b1);
    pulse(1, 8'd99);
    wait_done(1, c);
    chk("bcd_b_99", bcd_b, 8'h99);
    chk("ovf_b_99", ovf_b, 1'b0);

    // start while busy is ignored
    pulse(0, 8'd42);
    @(negedge clk);
    start_now(0, 8'd200);
    wait_done(0, c);
    chk("ignore_latency", c + 2, 8);
    chk("bcd_42", bcd_a, 12'h042);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_second_done", done_a | busy_a, 1'b0);
    end

    // Reset mid-conversion
    pulse(0, 8'd123);
    wait_done(0, c);
    chk("bcd_123", bcd_a, 12'h123);
    pulse(0, 8'd9);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_bcd",  bcd_a,  12'h000);
    chk("abort_ovf",  ovf_a,  1'b0);
    chk("abort_done", done_a, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_a, 1'b0);
    end
    pulse(0, 8'd9);
    wait_done(0, c);
    chk("latency_9", c, 8);
    chk("bcd_9", bcd_a, 12'h009);

    // Exhaustive sweep on the 3-digit instance
    for (int v = 0; v < 256; v++) begin
      pulse(0, 8'(v));
      wait_done(0, c);
      for (int d = 0; d < 3; d++) chk("digit_le9", bcd_a[4*d +: 4] <= 4'd9, 1'b1);
    end

    // Random start/bin on both instances, including starts while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      start_a = ($urandom_range(0, 3) == 0);
      start_b = ($urandom_range(0, 2) == 0);
      bin_a   = 8'($urandom);
      bin_b   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(90, 110)) : 8'($urandom);
    end
    @(negedge clk);
    #1 start_a = 1'b0; start_b = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the 7-segment decoders: each 4-bit digit of bcd drives one decoder instance.
- Out-of-range values produce 4'hF on every digit; the decoders render 4'hF as a dash.
- Start/busy/done handshake, one bit converted per clock.

Parameters:
- WIDTH, 8, bit width of the binary input; also the number of shift cycles per conversion.
- DIGITS, 3, number of BCD digits produced; capacity is 10^DIGITS - 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request, sampled on rising clk edge.
- bin  input  WIDTH  unsigned value, captured on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse when bcd/ovf update.
- bcd  output  4*DIGITS  packed result; digit i at bits [4i+3:4i]; digit 0 = units.
- ovf  output  1  high when the last converted value exceeded 10^DIGITS - 1.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd=0, ovf=0, scratch registers cleared. Release is synchronous to the next edge.
- FSM states: IDLE, SHIFT, DONE. Encoded with registered outputs.
- IDLE:
  - Remain in IDLE while start=0.
  - On start=1: capture bin into the shift register, clear the BCD scratch (4*DIGITS bits), load cnt=WIDTH, latch ovf_pending=(bin > 10^DIGITS-1), then go to SHIFT.
- SHIFT, one iteration per cycle:
  - Each scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {scratch, shreg} shifts left by 1; the MSB of shreg enters scratch bit 0.
  - cnt decrements each cycle. When cnt reaches 1 on the current cycle, go to DONE.
  - Exactly WIDTH SHIFT cycles.
- Entry to DONE, same edge as the final shift:
  - If ovf_pending, bcd <= all 4'hF; otherwise bcd <= final scratch.
  - ovf <= ovf_pending.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE.
  - start=1 during DONE is accepted exactly as in IDLE (DONE -> SHIFT), so back-to-back conversions are possible.
- Timing:
  - busy=1 exactly in SHIFT cycles; done and busy are never high together.
  - Latency: with start accepted at edge E0, busy is high for cycles after E0..E0+WIDTH-1, and done is high in the cycle after edge E0+WIDTH.
  - bcd/ovf are updated at that edge and stable until the next completion.
- start while busy=1 is ignored: no restart, and bin is not re-captured.
- bcd and ovf hold their previous values throughout a conversion, so there is no display flicker.
- 10^DIGITS - 1 is an elaboration-time constant. The comparison uses max(WIDTH, ceil(log2(10^DIGITS))) bits, so there is no truncation when WIDTH < log2(10^DIGITS).
- If WIDTH is small enough that the value can never exceed capacity, ovf is constant 0.
- Reset mid-conversion aborts immediately: outputs return to reset values and no done pulse is produced.

Test Plan:
- Default params: start=1 for one cycle, bin=8'd255 -> busy high 8 cycles; done pulses in the 9th cycle after the start edge; bcd=12'h255, ovf=0.
- bin=0, then bin=7, then bin=8'd100, issued back-to-back (start asserted during each DONE cycle) -> bcd sequence 12'h000, 12'h007, 12'h100; three done pulses spaced 9 cycles apart; busy never coincides with done.
- WIDTH=8, DIGITS=2, bin=8'd100 -> bcd=8'hFF, ovf=1. Then bin=8'd99 -> bcd=8'h99, ovf=0.
- Start at bin=8'd42; two cycles later pulse start with bin=8'd200 while busy -> a single done at the original latency; bcd=12'h042; no second conversion.
- Complete bin=8'd123 (bcd=12'h123). Start bin=8'd9; drop rst_n for 1 cycle at the 4th SHIFT cycle -> bcd=0, ovf=0, busy=0 immediately; no done. A fresh start with bin=8'd9 -> bcd=12'h009 after 9 cycles.
- Exhaustive sweep, WIDTH=8, DIGITS=3, bin 0..255 -> every bcd digit equals the decimal digit of bin, and no digit ever exceeds 9.
